// File: rtl/alu_core.sv
// rtl/alu_core.sv - multi-cycle 8-bit ALU with start/busy/done handshake and registered N/V/Z/C
//
// Optional feature macro: DECIMAL_MODE_EN (BCD adjust for ADC/SBC when the latched d_flag is set)
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous reset, active-high
//   AI, BI     operand bytes, latched on an accepted start
//   carry_in   C flag input, latched on start
//   d_flag     D flag input, latched on start (ignored unless DECIMAL_MODE_EN)
//   alu_op     operation select, latched on start
//   alu_start  request strobe, sampled only in IDLE
//   alu_out    registered result
//   alu_busy   high while an operation is in flight
//   alu_done   one-cycle pulse when alu_out and flags are updated
//   N, V, Z, C registered status flags
module alu_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] AI,
  input  logic [WIDTH-1:0] BI,
  input  logic             carry_in,
  input  logic             d_flag,
  input  logic [3:0]       alu_op,
  input  logic             alu_start,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_busy,
  output logic             alu_done,
  output logic             N,
  output logic             V,
  output logic             Z,
  output logic             C
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DADJ = 2'd2;

  localparam logic [3:0] OP_ADC = 4'd3;
  localparam logic [3:0] OP_SBC = 4'd4;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q;
  logic [3:0]       op_q;
  logic             go_dadj;

  // SBC reuses the adder with the inverted B operand; C=1 then means no borrow.
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   cmp_sum;

  assign b_eff   = (op_q == OP_SBC) ? ~b_q : b_q;
  assign sum     = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_q};
  assign cmp_sum = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] res;
  logic             n_nx, v_nx, z_nx, c_nx, upd_nz;

  always_comb begin
    res    = alu_out;
    n_nx   = N;
    v_nx   = V;
    z_nx   = Z;
    c_nx   = C;
    upd_nz = 1'b0;
    case (op_q)
      4'd0: begin res = a_q | b_q; upd_nz = 1'b1; end
      4'd1: begin res = a_q & b_q; upd_nz = 1'b1; end
      4'd2: begin res = a_q ^ b_q; upd_nz = 1'b1; end
      4'd3, 4'd4: begin
        res    = sum[WIDTH-1:0];
        c_nx   = sum[WIDTH];
        v_nx   = (a_q[7] == b_eff[7]) && (res[7] != a_q[7]);
        upd_nz = 1'b1;
      end
      4'd5: begin res = {a_q[6:0], 1'b0};  c_nx = a_q[7]; upd_nz = 1'b1; end
      4'd6: begin res = {1'b0, a_q[7:1]};  c_nx = a_q[0]; upd_nz = 1'b1; end
      4'd7: begin res = {a_q[6:0], cin_q}; c_nx = a_q[7]; upd_nz = 1'b1; end
      4'd8: begin res = {cin_q, a_q[7:1]}; c_nx = a_q[0]; upd_nz = 1'b1; end
      4'd9:  begin res = a_q + ONE; upd_nz = 1'b1; end
      4'd10: begin res = a_q - ONE; upd_nz = 1'b1; end
      4'd11: begin res = cmp_sum[WIDTH-1:0]; c_nx = cmp_sum[WIDTH]; upd_nz = 1'b1; end
      4'd12: begin
        res  = a_q & b_q;
        z_nx = (res == '0);
        n_nx = b_q[7];
        v_nx = b_q[6];
      end
      4'd13: begin res = a_q; upd_nz = 1'b1; end
      default: ;  // reserved: everything held
    endcase
    if (upd_nz) begin
      n_nx = res[7];
      z_nx = (res == '0);
    end
  end

`ifdef DECIMAL_MODE_EN
  logic d_q;
  logic [5:0] lo_raw, hi_raw, lo_adj, hi_adj;
  logic       lo_cy, hi_cy, dec_c;
  logic [WIDTH-1:0] dec_res;

  assign go_dadj = d_q && ((op_q == OP_ADC) || (op_q == OP_SBC));

  // Per-nibble BCD adjust. Carry/borrow out of the low nibble feeds the high
  // nibble; for SBC the final C is the binary no-borrow, as on NMOS parts.
  always_comb begin
    lo_raw = '0;
    hi_raw = '0;
    lo_adj = '0;
    hi_adj = '0;
    lo_cy  = 1'b0;
    hi_cy  = 1'b0;
    dec_c  = sum[WIDTH];
    if (op_q == OP_ADC) begin
      lo_raw = {2'b0, a_q[3:0]} + {2'b0, b_q[3:0]} + {5'b0, cin_q};
      lo_cy  = (lo_raw > 6'd9);
      lo_adj = lo_cy ? lo_raw + 6'd6 : lo_raw;
      hi_raw = {2'b0, a_q[7:4]} + {2'b0, b_q[7:4]} + {5'b0, lo_cy};
      hi_cy  = (hi_raw > 6'd9);
      hi_adj = hi_cy ? hi_raw + 6'd6 : hi_raw;
      dec_c  = hi_cy;
    end else begin
      lo_raw = {2'b0, a_q[3:0]} - {2'b0, b_q[3:0]} - {5'b0, ~cin_q};
      lo_cy  = lo_raw[5];
      lo_adj = lo_cy ? lo_raw - 6'd6 : lo_raw;
      hi_raw = {2'b0, a_q[7:4]} - {2'b0, b_q[7:4]} - {5'b0, lo_cy};
      hi_cy  = hi_raw[5];
      hi_adj = hi_cy ? hi_raw - 6'd6 : hi_raw;
    end
    dec_res = {hi_adj[3:0], lo_adj[3:0]};
  end
`else
  logic unused_d_flag;
  assign unused_d_flag = d_flag;
  assign go_dadj       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      alu_out  <= '0;
      N        <= 1'b0;
      V        <= 1'b0;
      Z        <= 1'b0;
      C        <= 1'b0;
      alu_busy <= 1'b0;
      alu_done <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      op_q     <= 4'd0;
`ifdef DECIMAL_MODE_EN
      d_q      <= 1'b0;
`endif
    end else begin
      alu_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (alu_start) begin
            a_q      <= AI;
            b_q      <= BI;
            cin_q    <= carry_in;
            op_q     <= alu_op;
`ifdef DECIMAL_MODE_EN
            d_q      <= d_flag;
`endif
            alu_busy <= 1'b1;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (go_dadj) begin
            state <= S_DADJ;
          end else begin
            alu_out  <= res;
            N        <= n_nx;
            V        <= v_nx;
            Z        <= z_nx;
            C        <= c_nx;
            alu_done <= 1'b1;
            alu_busy <= 1'b0;
            state    <= S_IDLE;
          end
        end
`ifdef DECIMAL_MODE_EN
        S_DADJ: begin
          // N, V, Z come from the binary sum; only the value and C are BCD.
          alu_out  <= dec_res;
          N        <= n_nx;
          V        <= v_nx;
          Z        <= z_nx;
          C        <= dec_c;
          alu_done <= 1'b1;
          alu_busy <= 1'b0;
          state    <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - self-checking bench for alu_core
module tb_alu_core;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] AI, BI;
  logic       carry_in, d_flag;
  logic [3:0] alu_op;
  logic       alu_start;
  logic [7:0] alu_out;
  logic       alu_busy, alu_done, N, V, Z, C;

  alu_core #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .AI(AI), .BI(BI), .carry_in(carry_in),
    .d_flag(d_flag), .alu_op(alu_op), .alu_start(alu_start),
    .alu_out(alu_out), .alu_busy(alu_busy), .alu_done(alu_done),
    .N(N), .V(V), .Z(Z), .C(C)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model state: result and flags as plain integers.
  int m_out, m_n, m_v, m_z, m_c;

  task automatic model_op(input int op, input int a, input int b, input int cin);
    int r, s, bb;
    r = m_out;
    case (op)
      0: r = a | b;
      1: r = a & b;
      2: r = a ^ b;
      3, 4: begin
        bb = (op == 4) ? 255 - b : b;
        s = a + bb + cin;
        r = s % 256;
        m_c = (s > 255);
        m_v = (((a ^ r) & (bb ^ r) & 128) != 0);
      end
      5: begin r = (a * 2) % 256; m_c = (a >= 128); end
      6: begin r = a / 2; m_c = a % 2; end
      7: begin r = (a * 2 + cin) % 256; m_c = (a >= 128); end
      8: begin r = a / 2 + cin * 128; m_c = a % 2; end
      9: r = (a + 1) % 256;
      10: r = (a + 255) % 256;
      11: begin r = (a - b + 256) % 256; m_c = (a >= b); end
      12: begin r = a & b; m_n = (b >= 128); m_v = (b / 64) % 2; m_z = (r == 0); end
      default: ;
    endcase
    if (op <= 11 || op == 13) begin
      if (op == 13) r = a;
      m_n = (r >= 128);
      m_z = (r == 0);
    end
    m_out = r;
  endtask

  // Issue one op; checks busy after acceptance, done latency in edges
  // counted from driving the start, and that operand changes after latch are ignored.
  task automatic run_op(input int op, input int a, input int b, input int cin,
                        input int d, input int exp_lat, input string tag);
    int lat;
    bit got;
    logic [7:0] av, bv;
    av = a[7:0];
    bv = b[7:0];
    @(negedge clk);
    AI = av; BI = bv; alu_op = op[3:0]; carry_in = cin[0]; d_flag = d[0]; alu_start = 1'b1;
    @(posedge clk); #1;
    check({tag, " busy"}, alu_busy, 1);
    @(negedge clk);
    alu_start = 1'b0; AI = ~av; BI = ~bv; carry_in = ~carry_in;
    lat = 1; got = 0;
    while (!got && lat < 6) begin
      @(posedge clk); #1;
      lat++;
      if (alu_done) got = 1;
    end
    check({tag, " latency"}, got ? lat : 99, exp_lat);
    check({tag, " busy_clr"}, alu_busy, 0);
  endtask

  typedef struct {
    int op, a, b, cin;
    int out, nvzc;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{3, 8'h50, 8'h50, 0, 8'hA0, 4'b1100};  // ADC signed overflow
    tbl[1] = '{4, 8'h00, 8'h01, 1, 8'hFF, 4'b1000};  // SBC borrow
    tbl[2] = '{11, 8'h40, 8'h40, 0, 8'h00, 4'b0011}; // CMP equal
    tbl[3] = '{8, 8'h01, 8'h00, 1, 8'h80, 4'b1001};  // ROR through carry
    tbl[4] = '{12, 8'h0F, 8'hC0, 0, 8'h00, 4'b1111}; // BIT, C held
    tbl[5] = '{14, 8'h12, 8'h34, 0, 8'h00, 4'b1111}; // reserved holds all
    tbl[6] = '{6, 8'h81, 8'h00, 0, 8'h40, 4'b0101};  // LSR
    tbl[7] = '{5, 8'h80, 8'h00, 0, 8'h00, 4'b0111};  // ASL to zero
    tbl[8] = '{2, 8'hFF, 8'h0F, 0, 8'hF0, 4'b1101};  // EOR
    tbl[9] = '{10, 8'h00, 8'h00, 0, 8'hFF, 4'b1101}; // DEC wrap

    reset = 1'b1; AI = '0; BI = '0; carry_in = 0; d_flag = 0; alu_op = '0; alu_start = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out", alu_out, 0);
    check("reset nvzc", {N, V, Z, C}, 0);
    check("reset busy", alu_busy, 0);
    check("reset done", alu_done, 0);

    // Reset aborting an in-flight ADC
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    AI = 8'h50; BI = 8'h50; alu_op = 4'd3; carry_in = 0; alu_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    alu_start = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort out", alu_out, 0);
    check("abort nvzc", {N, V, Z, C}, 0);
    check("abort busy", alu_busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort no_done", alu_done, 0);
    end

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, 0, 2, $sformatf("vec%0d", i));
      check($sformatf("vec%0d out", i), alu_out, tbl[i].out);
      check($sformatf("vec%0d nvzc", i), {N, V, Z, C}, tbl[i].nvzc);
    end

    // Decimal-flagged ADC 09+01
`ifdef DECIMAL_MODE_EN
    run_op(3, 8'h09, 8'h01, 0, 1, 3, "dec_adc");
    check("dec_adc out", alu_out, 8'h10);
    m_out = 8'h10;
`else
    run_op(3, 8'h09, 8'h01, 0, 1, 2, "dec_adc");
    check("dec_adc out", alu_out, 8'h0A);
    m_out = 8'h0A;
`endif
    check("dec_adc nvzc", {N, V, Z, C}, 4'b0000);
    m_n = 0; m_v = 0; m_z = 0; m_c = 0;

    // Start held high with INC 0xFF: done after edges 2, 4, 6 only
    @(negedge clk);
    AI = 8'hFF; BI = 8'h00; alu_op = 4'd9; carry_in = 0; d_flag = 0; alu_start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold done@%0d", i), alu_done, (i % 2) == 0);
    end
    @(negedge clk);
    alu_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold no_extra", alu_done, 0);
    end
    model_op(9, 255, 0, 0);
    check("hold out", alu_out, m_out);
    check("hold nvzc", {N, V, Z, C}, {m_n[0], m_v[0], m_z[0], m_c[0]});

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      int op, a, b, cin;
      op = $urandom_range(15, 0);
      a = $urandom_range(255, 0);
      b = $urandom_range(255, 0);
      cin = $urandom_range(1, 0);
      run_op(op, a, b, cin, 0, 2, $sformatf("rnd%0d", i));
      model_op(op, a, b, cin);
      check($sformatf("rnd%0d op%0d out", i, op), alu_out, m_out);
      check($sformatf("rnd%0d op%0d nvzc", i, op), {N, V, Z, C},
            {m_n[0], m_v[0], m_z[0], m_c[0]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
